sqrt_arbiter: RTL
=================

// Module: sqrt_arbiter
// PURPOSE
//  Shares one iterative sqrt unit among N_REQ requesters with round-robin arbitration.
//  Sits between the requester ports and the sqrt din/din_valid/din_ready/dout/dout_valid interface.
//  Keeps exactly one transaction in flight.
//  Returns each result to the requester that issued it, holding it until that requester accepts it.
// PARAMETERS
//  N_REQ   4   number of requesters (>=2)
//  DIN_W   32  operand width; DOUT_W = DIN_W/2 + DIN_W%2 (localparam)
//  ID_W: localparam, $clog2(N_REQ), minimum 1.
// PORTS
//  clk         in   1             clock, all logic on rising edge
//  rst_n       in   1             asynchronous reset, active-low
//  req_valid   in   N_REQ         per-requester operand valid
//  req_data    in   N_REQ*DIN_W   operands; requester i at [i*DIN_W +: DIN_W]
//  req_ready   out  N_REQ         one-hot accept pulse for the granted requester
//  rsp_valid   out  N_REQ         one-hot result valid, held until accepted
//  rsp_data    out  DOUT_W        result, common to all requesters
//  rsp_ready   in   N_REQ         per-requester result accept
//  sq_din      out  DIN_W         operand to the sqrt unit
//  sq_din_valid out 1             operand valid to the sqrt unit
//  sq_din_ready in  1             sqrt unit ready
//  sq_dout     in   DOUT_W        sqrt result
//  sq_dout_valid in 1             sqrt result strobe, no backpressure
//  busy        out  1             high in any state other than IDLE
//  grant_id    out  ID_W          index of the current or last granted requester
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=IDLE, rr_ptr=0, grant_id=0.
//   Held at 0 during reset: req_ready, rsp_valid, sq_din_valid, busy, and the sq_din, rsp_data registers.
//  Handshake rule: a transfer happens on a rising edge where valid&ready are both high.
//  FSM states:
//   IDLE  -> if any req_valid: grant g = first set bit scanning rr_ptr, rr_ptr+1, ... (mod N_REQ).
//            Latch req_data[g] into sq_din, set grant_id=g, pulse req_ready[g] for one cycle.
//            Next state ISSUE. With no request, stay in IDLE.
//   ISSUE -> drive sq_din_valid=1 and keep sq_din stable until sq_din_valid&sq_din_ready.
//            Then drop sq_din_valid and go to WAIT.
//   WAIT  -> on sq_dout_valid: latch sq_dout into rsp_data, go to RESP.
//   RESP  -> rsp_valid[grant_id]=1 and rsp_data stable.
//            On rsp_ready[grant_id]: drop rsp_valid, set rr_ptr=(grant_id+1) mod N_REQ, go to IDLE.
//  Latency: first accept one cycle after req_valid rises (FSM in IDLE).
//   The issued operand is seen at the sqrt input on the next cycle.
//   rsp_valid rises one cycle after sq_dout_valid.
//   One operation needs at least 2 cycles in IDLE/ISSUE, plus sqrt latency, plus 1 (RESP) plus the rsp wait.
//  Outstanding: never more than one operation in flight.
//   req_ready stays 0 outside the IDLE grant cycle.
//  req_ready is a registered pulse. Requesters must hold req_valid/req_data until they see it.
//  sq_dout_valid outside WAIT is ignored, e.g. a stale result after reset.
//  rsp_ready from non-granted requesters is ignored. rsp_ready held high while idle has no effect.
//  A requester that drops req_valid before it is granted is skipped, with no error.
//  Fairness: after a grant to g, g has lowest priority. Each continuously requesting port waits
//   at most N_REQ-1 operations.
//  busy = (state != IDLE).
//  grant_id keeps its value in IDLE until the next grant.
//  Reset mid-operation returns to IDLE immediately. Any in-flight result is discarded.
// TESTING
//  Single: req_valid[1]=1, data 144, rsp_ready[1]=1 -> one req_ready[1] pulse, rsp_valid[1] with rsp_data=12, grant_id=1.
//  Corners (DIN_W=32): 0->0, 1->1, 0x7FFFFFFF->46340 (0xB504), 0xFFFFFFFF->65535, each via a different requester.
//  Contention: all 4 valid at once (data 4,9,16,25) -> service order 0,1,2,3, results 2,3,4,5, each to its own port.
//  Fairness: req0 and req2 held valid for 6 ops -> grant order 0,2,0,2,0,2. req1 and req3 are never granted.
//  Backpressure: hold rsp_ready low 20 cycles in RESP -> rsp_valid and rsp_data stable, sq_din_valid=0, req_ready=0.
//   Release -> one accept, then IDLE.
//  Reset in WAIT: drop rst_n for 2 cycles during a sqrt op -> all outputs 0, state IDLE.
//   The next request (data 81) returns 9 from port 0 priority (rr_ptr=0).

Source files
------------

// File: rtl/sqrt_arbiter.sv
// Round-robin front end that shares one iterative sqrt unit among N_REQ requesters.
// Latency: grant 1 cycle after req_valid in IDLE, operand at the sqrt input the next cycle, rsp_valid 1 cycle after sq_dout_valid.
// Backpressure: one op in flight; sq_din is held until sq_din_ready, the result is held until the owner's rsp_ready.
module sqrt_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DIN_W  = 32,
  localparam int DOUT_W = DIN_W / 2 + DIN_W % 2,
  localparam int ID_W   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*DIN_W-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [DOUT_W-1:0]      rsp_data,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [DIN_W-1:0]       sq_din,
  output logic                   sq_din_valid,
  input  logic                   sq_din_ready,
  input  logic [DOUT_W-1:0]      sq_dout,
  input  logic                   sq_dout_valid,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;
  logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DIN_W-1:0]  sq_din_q, sq_din_d;
  logic              sq_din_valid_q, sq_din_valid_d;
  logic [DOUT_W-1:0] rsp_data_q, rsp_data_d;

  logic              hi_found;
  logic [ID_W-1:0]   pick_hi, pick_lo, pick;
  logic [DIN_W-1:0]  dat_hi, dat_lo, pick_dat;

  // Round-robin pick: lowest requester at or above rr_ptr, else wrap to the lowest requester overall.
  always_comb begin
    hi_found = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    dat_hi   = '0;
    dat_lo   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_lo = ID_W'(i);
        dat_lo  = req_data[i*DIN_W +: DIN_W];
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          pick_hi  = ID_W'(i);
          dat_hi   = req_data[i*DIN_W +: DIN_W];
        end
      end
    end
    pick     = hi_found ? pick_hi : pick_lo;
    pick_dat = hi_found ? dat_hi : dat_lo;
  end

  // Next-state and registered-output logic; every register holds unless its state acts on it.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    req_ready_d    = '0;
    rsp_valid_d    = rsp_valid_q;
    sq_din_d       = sq_din_q;
    sq_din_valid_d = sq_din_valid_q;
    rsp_data_d     = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d           = pick;
          sq_din_d          = pick_dat;
          req_ready_d[pick] = 1'b1;
          sq_din_valid_d    = 1'b1;
          state_d           = ISSUE;
        end
      end
      ISSUE: begin
        if (sq_din_ready) begin
          sq_din_valid_d = 1'b0;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        if (sq_dout_valid) begin
          rsp_data_d           = sq_dout;
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = RESP;
        end
      end
      RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      req_ready_q    <= '0;
      rsp_valid_q    <= '0;
      sq_din_q       <= '0;
      sq_din_valid_q <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      sq_din_q       <= sq_din_d;
      sq_din_valid_q <= sq_din_valid_d;
      rsp_data_q     <= rsp_data_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign sq_din       = sq_din_q;
  assign sq_din_valid = sq_din_valid_q;
  assign busy         = (state_q != IDLE);
  assign grant_id     = grant_q;

endmodule
